bus_uart_tx: RTL

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_uart_tx_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/bus_uart_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bus_uart_tx_pkg.sv
// Shared register map, STATUS bit layout and TX state encodings for bus_uart_tx.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bus_uart_tx_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [31:0] REG_DATA_OFF   = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS_OFF = 32'h0000_0004;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;

    // Transmitter states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Assemble the STATUS read word from its fields
    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       empty,
                                                input logic       full,
                                                input logic       busy);
        logic [31:0] w;
        w                         = '0;
        w[STAT_BUSY_BIT]          = busy;
        w[STAT_FULL_BIT]          = full;
        w[STAT_EMPTY_BIT]         = empty;
        w[STAT_OVF_BIT]           = ovf;
        w[STAT_COUNT_LSB +: 8]    = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output (dout is the current head).
// Latency: a pushed entry is visible on dout/count the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA write queues a byte, STATUS reports queue/line state.
// Latency: bus_rdata one cycle after address; first start bit one cycle after the DATA write edge.
// Backpressure: none on the bus; writes to a full queue are dropped and latch the sticky ovf flag.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    output logic [31:0] bus_rdata,
    output logic        uart_tx
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    // Bus decode
    logic addr_data, addr_status, wr_data, wr_status;
    assign addr_data   = (bus_addr == BASE_ADDR + REG_DATA_OFF);
    assign addr_status = (bus_addr == BASE_ADDR + REG_STATUS_OFF);
    assign wr_data     = bus_we && addr_data;
    assign wr_status   = bus_we && addr_status;

    // FIFO hookup
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [8:0]    count_ext;

    assign fifo_push = wr_data && !fifo_full;
    assign count_ext = 9'(fifo_count);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State
    tx_state_t   state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy;

    assign busy      = (state_q != TX_IDLE);
    assign uart_tx   = tx_q;
    assign bus_rdata = rdata_q;

    // Sticky overflow: the full test uses pre-edge occupancy, and a new overflow beats a clear
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && bus_wdata[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (wr_data && fifo_full)                 ovf_d = 1'b1;
    end

    // Read mux; only STATUS returns data, everything else reads as zero
    always_comb begin
        rdata_d = '0;
        if (addr_status) begin
            rdata_d = status_word(count_ext[7:0], ovf_q, fifo_empty, fifo_full, busy);
        end
    end

    // TX sequencing; tx_d is the line level for the state being entered so the flop leads cleanly
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = TX_START;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_RELOAD;
                    bit_cnt_d  = '0;
                    state_d    = TX_DATA;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (baud_cnt_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset drives the line high immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
